// File: rtl/td4_program_loader.sv
// -----------------------------------------------------------------------------
// td4_program_loader
// Writable program store for the TD4 CPU. The CPU fetches instructions through
// Address -> Order exactly as it would from the instruction ROM. Images are
// streamed in over a byte-wide valid/ready port. An optional trailing checksum
// byte makes the byte sum of the whole image zero when the image is good. The
// CPU is held in reset (cpu_clr_n low) until a good image has been loaded and
// RELEASE_DELAY further cycles have elapsed.
//
// Ports:
//   CLK        system clock, rising edge
//   CLR        asynchronous active-low reset (clears state and memory)
//   start      level-sampled; begins a load from IDLE, RUN or ERROR
//   in_data    load byte
//   in_valid   in_data is valid
//   in_ready   loader accepts a byte this cycle (LOAD and CHECK)
//   Address    CPU program counter
//   Order      combinational read data, mem[Address]
//   cpu_clr_n  active-low CPU reset, straight from a flop
//   busy       high in LOAD, CHECK and RELEASE
//   done       one-cycle pulse on entry to RUN
//   error      high while in ERROR
// -----------------------------------------------------------------------------
module td4_program_loader #(
  parameter int DEPTH         = 16,
  parameter int ADDR_W        = 4,
  parameter int DATA_W        = 8,
  parameter int CHECKSUM_EN   = 1,
  parameter int RELEASE_DELAY = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Order,
  output logic              cpu_clr_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int DLY_W = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;

  logic [2:0]        state_r;
  logic [2:0]        state_next_s;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [DATA_W-1:0] sum_r;
  logic [DATA_W-1:0] sum_next_s;
  logic [DLY_W-1:0]  dly_r;
  logic              xfer_s;
  logic              last_s;
  logic              dly_last_s;
  logic              load_start_s;
  logic              in_ready_r;
  logic              cpu_clr_n_r;
  logic              busy_r;
  logic              done_r;
  logic              error_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  // Handshake and datapath helper terms.
  always_comb begin
    xfer_s       = in_valid & in_ready_r;
    last_s       = (wr_ptr_r == ADDR_W'(DEPTH - 1));
    sum_next_s   = sum_r + in_data;
    dly_last_s   = (dly_r == DLY_W'(RELEASE_DELAY - 1));
    load_start_s = (state_next_s == S_LOAD) && (state_r != S_LOAD);
  end

  // Next-state logic; start is only honoured outside LOAD/CHECK/RELEASE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) begin
          state_next_s = S_LOAD;
        end else begin
          state_next_s = state_r;
        end
      end
      S_LOAD: begin
        if (xfer_s && last_s) begin
          state_next_s = (CHECKSUM_EN != 0) ? S_CHECK : S_RELEASE;
        end else begin
          state_next_s = S_LOAD;
        end
      end
      S_CHECK: begin
        // A good image sums to zero including the checksum byte.
        if (xfer_s) begin
          if (sum_next_s == {DATA_W{1'b0}}) begin
            state_next_s = S_RELEASE;
          end else begin
            state_next_s = S_ERROR;
          end
        end else begin
          state_next_s = S_CHECK;
        end
      end
      S_RELEASE: begin
        if (dly_last_s) begin
          state_next_s = S_RUN;
        end else begin
          state_next_s = S_RELEASE;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // State, pointer, running sum, release counter and registered outputs.
  // Outputs are decoded from the next state so they line up with the state.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_r     <= S_IDLE;
      wr_ptr_r    <= {ADDR_W{1'b0}};
      sum_r       <= {DATA_W{1'b0}};
      dly_r       <= {DLY_W{1'b0}};
      in_ready_r  <= 1'b0;
      cpu_clr_n_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (load_start_s) begin
        wr_ptr_r <= {ADDR_W{1'b0}};
        sum_r    <= {DATA_W{1'b0}};
      end else if ((state_r == S_LOAD) && xfer_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
        sum_r    <= sum_next_s;
      end else begin
        wr_ptr_r <= wr_ptr_r;
        sum_r    <= sum_r;
      end
      if (state_r == S_RELEASE) begin
        dly_r <= dly_r + DLY_W'(1);
      end else begin
        dly_r <= {DLY_W{1'b0}};
      end
      in_ready_r  <= (state_next_s == S_LOAD) || (state_next_s == S_CHECK);
      busy_r      <= (state_next_s == S_LOAD) || (state_next_s == S_CHECK) ||
                     (state_next_s == S_RELEASE);
      cpu_clr_n_r <= (state_next_s == S_RUN);
      done_r      <= (state_next_s == S_RUN) && (state_r != S_RUN);
      error_r     <= (state_next_s == S_ERROR);
    end
  end

  // Program memory; reset wipes the whole image, checksum byte never stored.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if ((state_r == S_LOAD) && xfer_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end else begin
      mem_r <= mem_r;
    end
  end

  assign Order     = mem_r[Address];
  assign in_ready  = in_ready_r;
  assign cpu_clr_n = cpu_clr_n_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign error     = error_r;

endmodule

// File: tb/tb_td4_program_loader.sv
module tb_td4_program_loader;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] Address;
  logic [7:0] Order;
  logic       cpu_clr_n;
  logic       busy;
  logic       done;
  logic       error;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  logic prev_clr = 1'b0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic rnd;
    int   gap_max;
    logic corrupt;
    logic mid_start;
    logic exp_err;
  } vec_t;
  vec_t vecs [5];

  td4_program_loader dut (
    .CLK(CLK), .CLR(CLR), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .Address(Address),
    .Order(Order), .cpu_clr_n(cpu_clr_n), .busy(busy), .done(done),
    .error(error)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_with_cpu_clr_n", cpu_clr_n, 1);
    end
    if (cpu_clr_n === 1'b1 && prev_clr === 1'b0) chk("clr_rise_on_done", done, 1);
    prev_clr = cpu_clr_n;
  endtask

  task automatic check_reset_state();
    chk("rst_cpu_clr_n", cpu_clr_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_in_ready", in_ready, 0);
    for (int a = 0; a < 16; a++) begin
      Address = 4'(a);
      #1;
      chk("rst_order", Order, 0);
    end
  endtask

  task automatic run_load(input logic rnd, input int gap_max, input logic corrupt,
                          input logic mid_start, input logic exp_err);
    logic [7:0] img [16];
    logic [7:0] s;
    logic [7:0] ck;
    int gaps;
    int g;
    int k;
    s = 8'd0;
    gaps = 0;
    for (int i = 0; i < 16; i++) begin
      img[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(i);
      s = s + img[i];
    end
    ck = 8'd0 - s;
    if (corrupt) ck = ck - 8'd1;
    exp_q.delete();
    busy_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("load_entry_cpu_clr_n", cpu_clr_n, 0);
    chk("load_entry_error", error, 0);
    chk("load_entry_busy", busy, 1);
    for (int i = 0; i < 17; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0;
        chk("in_ready_gap", in_ready, 1);
        step();
        gaps++;
      end
      in_valid = 1'b1;
      in_data  = (i < 16) ? img[i] : ck;
      if (i < 16) exp_q.push_back(img[i]);
      if (mid_start && i == 5) start = 1'b1;
      chk("in_ready_xfer", in_ready, 1);
      step();
      start = 1'b0;
    end
    in_valid = 1'b0;
    k = 0;
    while (!(done_cnt > 0 || error === 1'b1) && k < 40) begin
      step();
      k++;
    end
    chk("load_completes", (k < 40), 1);
    repeat (2) step();
    chk("busy_cycles", busy_cnt, 17 + gaps + (exp_err ? 0 : 2));
    chk("done_pulses", done_cnt, exp_err ? 0 : 1);
    chk("error_flag", error, exp_err);
    chk("cpu_clr_n_final", cpu_clr_n, !exp_err);
    for (int a = 0; a < 16; a++) begin
      Address = 4'(a);
      #1;
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 0, 1);
      end else begin
        chk("mem_image", Order, exp_q.pop_front());
      end
    end
  endtask

  initial begin
    vecs[0] = '{rnd: 1'b0, gap_max: 0, corrupt: 1'b0, mid_start: 1'b0, exp_err: 1'b0};
    vecs[1] = '{rnd: 1'b0, gap_max: 0, corrupt: 1'b1, mid_start: 1'b0, exp_err: 1'b1};
    vecs[2] = '{rnd: 1'b0, gap_max: 0, corrupt: 1'b0, mid_start: 1'b0, exp_err: 1'b0};
    vecs[3] = '{rnd: 1'b1, gap_max: 3, corrupt: 1'b0, mid_start: 1'b0, exp_err: 1'b0};
    vecs[4] = '{rnd: 1'b1, gap_max: 0, corrupt: 1'b0, mid_start: 1'b1, exp_err: 1'b0};

    CLR = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'd0;
    Address = 4'd0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_state();
    #3;
    CLR = 1'b1;
    step();

    // Good, bad, recovery from ERROR, stalled reload from RUN, start during LOAD.
    for (int v = 0; v < 5; v++) begin
      run_load(vecs[v].rnd, vecs[v].gap_max, vecs[v].corrupt,
               vecs[v].mid_start, vecs[v].exp_err);
    end

    // Abort a load with CLR after 7 accepted bytes.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    #3;
    CLR = 1'b0;
    #1;
    check_reset_state();
    #2;
    CLR = 1'b1;
    prev_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      step();
      chk("idle_after_reset_ready", in_ready, 0);
      chk("idle_after_reset_busy", busy, 0);
    end
    in_valid = 1'b0;
    run_load(1'b1, 1, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
